// File: rtl/vend_if.sv
// vend_if: selection, coin, price lookup and vend/change result signals of the vending controller
interface vend_if;
   logic       sel_valid;
   logic [1:0] sel_code;
   logic [1:0] price_sel;
   logic [3:0] price;
   logic       coin_valid;
   logic [1:0] coin_code;
   logic       cancel;
   logic       busy;
   logic [4:0] credit;
   logic       dispense;
   logic [1:0] item;
   logic       change_valid;
   logic [4:0] change_amt;
   logic       coin_reject;
   modport master (
      output sel_valid, sel_code, price, coin_valid, coin_code, cancel,
      input  price_sel, busy, credit, dispense, item, change_valid, change_amt, coin_reject
   );
   modport slave (
      input  sel_valid, sel_code, price, coin_valid, coin_code, cancel,
      output price_sel, busy, credit, dispense, item, change_valid, change_amt, coin_reject
   );
endinterface

// File: rtl/vend_ctrl.sv
// vend_ctrl: coin-collecting vending FSM with exact/over-pay vend, change, cancel refund and inactivity timeout
module vend_ctrl #(
   parameter int TIMEOUT = 16
) (
   input logic   clk,
   input logic   rst,
   vend_if.slave bus
);
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   typedef enum logic [2:0] {IDLE, COLLECT, VEND, CHANGE, REFUND} state_t;
   state_t        state_q, state_d;
   logic [1:0]    price_sel_q, price_sel_d;
   logic [4:0]    credit_q, credit_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          coin_reject_q, coin_reject_d;
   logic [4:0]    coin_amt, credit_sum, price_ext;
   assign coin_amt   = bus.coin_code == 2'b00 ? 5'd1 :
                       bus.coin_code == 2'b01 ? 5'd2 :
                       bus.coin_code == 2'b10 ? 5'd5 : 5'd10;
   assign credit_sum = credit_q + coin_amt;
   assign price_ext  = {1'b0, bus.price};
   // next-state: selection in IDLE, coin/cancel/timeout in COLLECT, single-cycle VEND/CHANGE/REFUND
   always_comb begin
      state_d       = state_q;
      price_sel_d   = price_sel_q;
      credit_d      = credit_q;
      tmo_d         = tmo_q;
      coin_reject_d = bus.coin_valid & ((state_q != COLLECT) | bus.cancel);
      case (state_q)
         IDLE: if (bus.sel_valid && bus.sel_code != 2'b11) begin
            price_sel_d = bus.sel_code;
            credit_d    = '0;
            tmo_d       = '0;
            state_d     = COLLECT;
         end
         COLLECT: if (bus.cancel) state_d = REFUND;
         else if (bus.coin_valid) begin
            credit_d = credit_sum;
            tmo_d    = '0;
            state_d  = credit_sum >= price_ext ? VEND : COLLECT;
         end
         else if (tmo_q == TW'(TIMEOUT - 1)) state_d = REFUND;
         else tmo_d = tmo_q + TW'(1);
         VEND: begin
            state_d  = credit_q > price_ext ? CHANGE : IDLE;
            credit_d = credit_q > price_ext ? credit_q : '0;
         end
         default: begin
            state_d  = IDLE;
            credit_d = '0;
         end
      endcase
   end
   // state registers, cleared asynchronously so a reset drops any pending credit silently
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         price_sel_q   <= '0;
         credit_q      <= '0;
         tmo_q         <= '0;
         coin_reject_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         price_sel_q   <= price_sel_d;
         credit_q      <= credit_d;
         tmo_q         <= tmo_d;
         coin_reject_q <= coin_reject_d;
      end
   end
   assign bus.price_sel    = price_sel_q;
   assign bus.credit       = credit_q;
   assign bus.coin_reject  = coin_reject_q;
   assign bus.busy         = state_q != IDLE;
   assign bus.dispense     = state_q == VEND;
   assign bus.item         = state_q == VEND ? price_sel_q : 2'b00;
   assign bus.change_valid = (state_q == CHANGE) | ((state_q == REFUND) & (credit_q != 5'd0));
   assign bus.change_amt   = state_q == CHANGE ? credit_q - price_ext :
                             state_q == REFUND ? credit_q : 5'd0;
endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: directed scenarios plus randomized purchases checked against a transaction-level model
module tb_vend_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   vend_if bus ();
   vend_ctrl #(.TIMEOUT(16)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   function automatic int price_of(input logic [1:0] c);
      return c == 2'd0 ? 5 : c == 2'd1 ? 7 : c == 2'd2 ? 10 : 0;
   endfunction
   function automatic int coin_of(input logic [1:0] c);
      return c == 2'd0 ? 1 : c == 2'd1 ? 2 : c == 2'd2 ? 5 : 10;
   endfunction
   assign bus.price = 4'(price_of(bus.price_sel));
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic idle_in();
      bus.sel_valid = 0; bus.sel_code = 0; bus.coin_valid = 0; bus.coin_code = 0; bus.cancel = 0;
   endtask
   task automatic test_reset();
      idle_in();
      tick();
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
      checks++; if (bus.credit !== 5'd0) begin errors++; $display("FAIL reset_credit got=%0d exp=0", bus.credit); end
      checks++; if ({bus.dispense, bus.item, bus.change_valid, bus.change_amt, bus.coin_reject, bus.price_sel} !== 12'd0) begin
         errors++; $display("FAIL reset_outputs got=%h exp=0", {bus.dispense, bus.item, bus.change_valid, bus.change_amt, bus.coin_reject, bus.price_sel}); end
      rst = 0;
   endtask
   task automatic test_exact();
      bus.sel_valid = 1; bus.sel_code = 2'b01; tick(); idle_in();
      checks++; if (bus.busy !== 1'b1 || bus.price_sel !== 2'b01) begin errors++; $display("FAIL exact_sel got busy=%0b ps=%0d exp busy=1 ps=1", bus.busy, bus.price_sel); end
      bus.coin_valid = 1; bus.coin_code = 2'b10; tick(); idle_in();
      checks++; if (bus.credit !== 5'd5 || bus.dispense !== 1'b0) begin errors++; $display("FAIL exact_c1 got credit=%0d disp=%0b exp 5/0", bus.credit, bus.dispense); end
      bus.coin_valid = 1; bus.coin_code = 2'b01; tick(); idle_in();
      checks++; if (bus.credit !== 5'd7 || bus.dispense !== 1'b1 || bus.item !== 2'b01 || bus.change_valid !== 1'b0) begin
         errors++; $display("FAIL exact_vend got credit=%0d disp=%0b item=%0d cv=%0b exp 7/1/1/0", bus.credit, bus.dispense, bus.item, bus.change_valid); end
      tick();
      checks++; if (bus.credit !== 5'd0 || bus.busy !== 1'b0 || bus.dispense !== 1'b0 || bus.change_valid !== 1'b0 || bus.item !== 2'd0) begin
         errors++; $display("FAIL exact_done got credit=%0d busy=%0b disp=%0b cv=%0b item=%0d exp all 0", bus.credit, bus.busy, bus.dispense, bus.change_valid, bus.item); end
   endtask
   task automatic test_overpay();
      bus.sel_valid = 1; bus.sel_code = 2'b00; tick(); idle_in();
      bus.coin_valid = 1; bus.coin_code = 2'b01; tick(); idle_in();
      checks++; if (bus.credit !== 5'd2) begin errors++; $display("FAIL over_c1 got credit=%0d exp=2", bus.credit); end
      bus.coin_valid = 1; bus.coin_code = 2'b11; tick(); idle_in();
      checks++; if (bus.credit !== 5'd12 || bus.dispense !== 1'b1 || bus.item !== 2'b00 || bus.change_valid !== 1'b0) begin
         errors++; $display("FAIL over_vend got credit=%0d disp=%0b item=%0d cv=%0b exp 12/1/0/0", bus.credit, bus.dispense, bus.item, bus.change_valid); end
      tick();
      checks++; if (bus.change_valid !== 1'b1 || bus.change_amt !== 5'd7 || bus.dispense !== 1'b0) begin
         errors++; $display("FAIL over_change got cv=%0b amt=%0d disp=%0b exp 1/7/0", bus.change_valid, bus.change_amt, bus.dispense); end
      tick();
      checks++; if (bus.change_valid !== 1'b0 || bus.change_amt !== 5'd0 || bus.busy !== 1'b0 || bus.credit !== 5'd0) begin
         errors++; $display("FAIL over_done got cv=%0b amt=%0d busy=%0b credit=%0d exp all 0", bus.change_valid, bus.change_amt, bus.busy, bus.credit); end
   endtask
   task automatic test_cancel();
      bus.sel_valid = 1; bus.sel_code = 2'b10; tick(); idle_in();
      bus.coin_valid = 1; bus.coin_code = 2'b10; tick(); idle_in();
      bus.cancel = 1; bus.coin_valid = 1; bus.coin_code = 2'b11; tick(); idle_in();
      checks++; if (bus.coin_reject !== 1'b1 || bus.change_valid !== 1'b1 || bus.change_amt !== 5'd5 || bus.dispense !== 1'b0 || bus.credit !== 5'd5) begin
         errors++; $display("FAIL cancel_refund got rej=%0b cv=%0b amt=%0d disp=%0b credit=%0d exp 1/1/5/0/5", bus.coin_reject, bus.change_valid, bus.change_amt, bus.dispense, bus.credit); end
      tick();
      checks++; if (bus.coin_reject !== 1'b0 || bus.change_valid !== 1'b0 || bus.busy !== 1'b0) begin
         errors++; $display("FAIL cancel_done got rej=%0b cv=%0b busy=%0b exp 0/0/0", bus.coin_reject, bus.change_valid, bus.busy); end
   endtask
   task automatic test_timeout();
      bus.sel_valid = 1; bus.sel_code = 2'b01; tick(); idle_in();
      bus.coin_valid = 1; bus.coin_code = 2'b00; tick(); idle_in();
      for (int i = 1; i <= 15; i++) begin
         tick();
         checks++; if (bus.change_valid !== 1'b0 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL timeout_early cycle=%0d got cv=%0b busy=%0b exp 0/1", i, bus.change_valid, bus.busy); end
      end
      tick();
      checks++; if (bus.change_valid !== 1'b1 || bus.change_amt !== 5'd1) begin
         errors++; $display("FAIL timeout_refund got cv=%0b amt=%0d exp 1/1", bus.change_valid, bus.change_amt); end
      tick();
      checks++; if (bus.busy !== 1'b0 || bus.credit !== 5'd0) begin errors++; $display("FAIL timeout_done got busy=%0b credit=%0d exp 0/0", bus.busy, bus.credit); end
   endtask
   task automatic test_idle_inputs();
      bus.coin_valid = 1; bus.coin_code = 2'b11; tick(); idle_in();
      checks++; if (bus.coin_reject !== 1'b1 || bus.credit !== 5'd0 || bus.busy !== 1'b0) begin
         errors++; $display("FAIL idle_coin got rej=%0b credit=%0d busy=%0b exp 1/0/0", bus.coin_reject, bus.credit, bus.busy); end
      bus.sel_valid = 1; bus.sel_code = 2'b11; bus.cancel = 1; tick(); idle_in();
      checks++; if (bus.busy !== 1'b0 || bus.price_sel !== 2'b01 || bus.coin_reject !== 1'b0 || bus.change_valid !== 1'b0) begin
         errors++; $display("FAIL idle_sel11 got busy=%0b ps=%0d rej=%0b cv=%0b exp 0/1/0/0", bus.busy, bus.price_sel, bus.coin_reject, bus.change_valid); end
   endtask
   task automatic test_reset_mid();
      bus.sel_valid = 1; bus.sel_code = 2'b10; tick(); idle_in();
      bus.coin_valid = 1; bus.coin_code = 2'b10; tick(); idle_in();
      checks++; if (bus.credit !== 5'd5) begin errors++; $display("FAIL rmid_credit got=%0d exp=5", bus.credit); end
      #1 rst = 1;
      #1;
      checks++; if ({bus.busy, bus.credit, bus.price_sel, bus.dispense, bus.change_valid, bus.change_amt, bus.coin_reject, bus.item} !== 18'd0) begin
         errors++; $display("FAIL rmid_async got=%h exp=0", {bus.busy, bus.credit, bus.price_sel, bus.dispense, bus.change_valid, bus.change_amt, bus.coin_reject, bus.item}); end
      tick();
      rst = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (bus.change_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL rmid_release cycle=%0d got cv=%0b busy=%0b exp 0/0", i, bus.change_valid, bus.busy); end
      end
      bus.sel_valid = 1; bus.sel_code = 2'b00; tick(); idle_in();
      checks++; if (bus.busy !== 1'b1 || bus.price_sel !== 2'b00) begin errors++; $display("FAIL rmid_first_sel got busy=%0b ps=%0d exp 1/0", bus.busy, bus.price_sel); end
      bus.cancel = 1; tick(); idle_in();
      checks++; if (bus.change_valid !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL rmid_zero_refund got cv=%0b busy=%0b exp 0/1", bus.change_valid, bus.busy); end
      tick();
   endtask
   task automatic test_random();
      for (int t = 0; t < 40; t++) begin
         logic [1:0] ps, cc;
         int p, sum, n, cancel_at;
         bit done, cv;
         ps = 2'($urandom_range(0, 2));
         p = price_of(ps);
         sum = 0; n = 0; done = 0;
         cancel_at = $urandom_range(0, 5);
         bus.sel_valid = 1; bus.sel_code = ps; tick(); idle_in();
         checks++; if (bus.price_sel !== ps || bus.busy !== 1'b1 || bus.credit !== 5'd0) begin
            errors++; $display("FAIL rnd_sel t=%0d got ps=%0d busy=%0b credit=%0d exp %0d/1/0", t, bus.price_sel, bus.busy, bus.credit, ps); end
         while (!done) begin
            repeat ($urandom_range(0, 2)) begin
               bus.sel_valid = 1'($urandom_range(0, 1)); bus.sel_code = 2'($urandom_range(0, 3)); tick(); idle_in();
               checks++; if (bus.credit !== 5'(sum) || bus.busy !== 1'b1 || bus.price_sel !== ps || bus.dispense !== 1'b0) begin
                  errors++; $display("FAIL rnd_gap t=%0d got credit=%0d busy=%0b ps=%0d disp=%0b exp %0d/1/%0d/0", t, bus.credit, bus.busy, bus.price_sel, bus.dispense, sum, ps); end
            end
            if (n == cancel_at) begin
               cv = 1'($urandom_range(0, 1));
               bus.cancel = 1; bus.coin_valid = cv; bus.coin_code = 2'($urandom_range(0, 3)); tick(); idle_in();
               checks++; if (bus.change_valid !== (sum > 0) || bus.change_amt !== 5'(sum) || bus.coin_reject !== cv || bus.dispense !== 1'b0) begin
                  errors++; $display("FAIL rnd_cancel t=%0d got cv=%0b amt=%0d rej=%0b disp=%0b exp %0b/%0d/%0b/0", t, bus.change_valid, bus.change_amt, bus.coin_reject, bus.dispense, sum > 0, sum, cv); end
               done = 1;
            end else begin
               cc = 2'($urandom_range(0, 3));
               sum += coin_of(cc);
               bus.coin_valid = 1; bus.coin_code = cc; tick(); idle_in();
               if (sum >= p) begin
                  checks++; if (bus.dispense !== 1'b1 || bus.item !== ps || bus.credit !== 5'(sum) || bus.change_valid !== 1'b0) begin
                     errors++; $display("FAIL rnd_vend t=%0d got disp=%0b item=%0d credit=%0d cv=%0b exp 1/%0d/%0d/0", t, bus.dispense, bus.item, bus.credit, bus.change_valid, ps, sum); end
                  tick();
                  checks++; if (bus.change_valid !== (sum > p) || bus.change_amt !== 5'(sum - p) || bus.dispense !== 1'b0) begin
                     errors++; $display("FAIL rnd_change t=%0d got cv=%0b amt=%0d disp=%0b exp %0b/%0d/0", t, bus.change_valid, bus.change_amt, bus.dispense, sum > p, sum - p); end
                  if (sum > p) tick();
                  checks++; if (bus.busy !== 1'b0 || bus.credit !== 5'd0) begin
                     errors++; $display("FAIL rnd_end t=%0d got busy=%0b credit=%0d exp 0/0", t, bus.busy, bus.credit); end
                  done = 1;
               end else begin
                  checks++; if (bus.credit !== 5'(sum) || bus.dispense !== 1'b0 || bus.coin_reject !== 1'b0) begin
                     errors++; $display("FAIL rnd_coin t=%0d got credit=%0d disp=%0b rej=%0b exp %0d/0/0", t, bus.credit, bus.dispense, bus.coin_reject, sum); end
               end
               n++;
            end
         end
         if (bus.busy) tick();
      end
   endtask
   initial begin
      idle_in();
      test_reset();
      test_exact();
      test_overpay();
      test_cancel();
      test_timeout();
      test_idle_inputs();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/vend_ctrl.md
VEND_CTRL -- requirements
Module: vend_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16, meaning the number of consecutive no-coin cycles in COLLECT before an auto-refund.
REQ-002 clk  input  1  Single clock; all state changes on the rising edge.
REQ-003 rst  input  1  Asynchronous, active-high reset.
REQ-004 sel_valid  input  1  Product selection strobe.
REQ-005 sel_code  input  2  Product code, sampled with sel_valid.
REQ-006 price_sel  output  2  Registered select driven to the price_select instance.
REQ-007 price  input  4  Price returned combinationally by price_select for price_sel; map 00->5, 01->7, 10->10, 11->0.
REQ-008 coin_valid  input  1  Coin strobe, one cycle per coin.
REQ-009 coin_code  input  2  Coin value: 00->1, 01->2, 10->5, 11->10.
REQ-010 cancel  input  1  User cancel request.
REQ-011 busy  output  1  High whenever state is not IDLE.
REQ-012 credit  output  5  Accumulated credit, unsigned.
REQ-013 dispense  output  1  One-cycle vend pulse.
REQ-014 item  output  2  Code of the vended product; valid while dispense is high.
REQ-015 change_valid  output  1  One-cycle change or refund pulse.
REQ-016 change_amt  output  5  Amount returned; valid while change_valid is high.
REQ-017 coin_reject  output  1  One-cycle pulse, registered, meaning a coin was not accepted.

Function
REQ-018 The block SHALL implement states IDLE, COLLECT, VEND, CHANGE and REFUND, with every output registered or decoded from state only.
REQ-019 IDLE behaviour: sel_valid with sel_code != 11 SHALL load price_sel, clear credit and the timeout counter, and go to COLLECT; sel_code 11 SHALL be ignored and the state remain IDLE.
REQ-020 sel_valid in any state other than IDLE SHALL be ignored; price_sel SHALL hold its value until the next accepted selection.
REQ-021 COLLECT behaviour: coin_valid without cancel SHALL add the coin value to credit; the sum is 5-bit, the maximum reachable is 9+10=19, and no overflow is possible.
REQ-022 COLLECT transition: if the updated credit is >= price, the next state SHALL be VEND; otherwise the state SHALL remain COLLECT.
REQ-023 cancel in COLLECT SHALL go to REFUND; a coin in the same cycle as cancel SHALL be rejected (coin_reject next cycle, credit unchanged).
REQ-024 Timeout counter: it SHALL clear on entry to COLLECT and on each accepted coin, and otherwise increment each COLLECT cycle; reaching TIMEOUT-1 with no coin or cancel SHALL go to REFUND.
REQ-025 VEND SHALL last one cycle with dispense=1 and item=price_sel; it SHALL go to CHANGE if credit > price, else to IDLE with credit cleared.
REQ-026 CHANGE SHALL last one cycle with change_valid=1, change_amt = credit - price (4-bit price zero-extended); credit SHALL clear and the state go to IDLE.
REQ-027 REFUND SHALL last one cycle; if credit > 0 it SHALL assert change_valid=1 with change_amt=credit; with credit = 0 no pulse is issued; credit SHALL clear and the state go to IDLE.
REQ-028 coin_valid in any state other than COLLECT SHALL produce coin_reject in the next cycle, with credit unchanged.
REQ-029 Latency: dispense SHALL be high in the cycle immediately after the edge that sampled the completing coin; change_valid, when issued, SHALL be high exactly one cycle later.
REQ-030 cancel outside COLLECT SHALL be ignored.
REQ-031 change_amt and item SHALL be 0 whenever their respective valid signal is low.

Reset
REQ-032 On rst assertion, regardless of clock, the block SHALL force state IDLE and set price_sel, credit, dispense, item, change_valid, change_amt, coin_reject and the timeout counter to 0, and busy to 0.
REQ-033 Reset mid-transaction SHALL discard credit without issuing a refund pulse.
REQ-034 The first accepted input after rst deasserts SHALL be at the first rising edge where rst is low.

Verification
REQ-035 Exact price: sel 01, coins 10(5) then 01(2) -> credit 5 then 7, dispense=1 with item=01 for one cycle, no change_valid, credit 0, busy 0.
REQ-036 Overpay: sel 00, coins 01(2) then 11(10) -> credit 12, dispense with item=00, next cycle change_valid with change_amt=7.
REQ-037 Cancel with same-cycle coin: sel 10, coin 10(5), then cancel together with coin 11 -> coin_reject pulse, change_valid with change_amt=5, no dispense.
REQ-038 Timeout with TIMEOUT=16: sel 01, coin 00(1), then no activity -> refund of change_amt=1 after 16 idle cycles, not before.
REQ-039 Idle coin and invalid selection: coin in IDLE -> coin_reject, credit 0; sel 11 -> busy stays 0, price_sel unchanged.
REQ-040 Reset mid-COLLECT: sel 10, coin 5, assert rst between edges -> all outputs 0 immediately, no change_valid after release.
